ddr_init_refresh_ctrl: RTL and testbench
========================================

# ddr_init_refresh_ctrl

Sequences DDR4 device power-up and schedules periodic refresh on the shared command bus. After reset it holds CKE low, raises CKE, and issues MRS3, MRS6, MRS5, MRS4, MRS2, MRS1, MRS0 and then ZQCL at fixed intervals. It then raises `init_done` and runs a tREFI refresh timer that asks the command arbiter for the bus with a req/gnt handshake. Pending refreshes are counted so the arbiter can postpone up to MAX_PEND of them.

## Interface
- tCKE_DLY, 16: cycles from `reset_n` deassertion to CKE rise
- tXPR, 20: cycles from CKE rise to the MRS3 command
- tMRD, 8: cycles between consecutive MRS commands
- tMOD, 24: cycles from MRS0 to ZQCL
- tZQ, 512: cycles from ZQCL to `init_done`
- tREFI, 780: refresh interval in cycles (must be > tRFC+2)
- tRFC, 36: cycles from REF until the bus is released
- MAX_PEND, 8: saturation limit of the pending-refresh counter
- CK_t  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- mr_cfg  in  98  mode register values; MRi = mr_cfg[14*i +: 14]; sampled when the MRS is issued
- ref_gnt  in  1  arbiter grant; the bus is idle and all banks are precharged
- CKE  out  1  clock enable
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins
- bg_addr  out  2  bank group
- ba_addr  out  2  bank address
- addr  out  14  A13..A0
- init_done  out  1  initialization complete; sticky until reset
- ref_req  out  1  refresh request to the arbiter
- ref_busy  out  1  high from the REF cycle through the end of tRFC
- ref_overflow  out  1  sticky; set when the timer expires while pending == MAX_PEND

## Operation
- All outputs are registered.
- Reset values: CKE=0, cs_n=act_n=RAS/CAS/WE=1, bg_addr=ba_addr=addr=0, init_done=ref_req=ref_busy=ref_overflow=0, pending=0.
- DES (driven whenever no command is issued): cs_n=1, act_n=RAS=CAS=WE=1, bg/ba/addr=0.
- Command encodings:
  - MRSi: cs_n=0, act_n=1, RAS=CAS=WE=0, bg_addr={1'b0,i[2]}, ba_addr=i[1:0], addr=MRi.
  - ZQCL: cs_n=0, act_n=1, RAS=1, CAS=1, WE=0, addr[10]=1, other addr bits=0.
  - REF: cs_n=0, act_n=1, RAS=0, CAS=0, WE=1.
- Every command lasts exactly one cycle.
- States: CKE_WAIT → XPR_WAIT → MRS_ISSUE ↔ MRD_WAIT (index order 3,6,5,4,2,1,0) → MOD_WAIT → ZQ_ISSUE → ZQ_WAIT → IDLE ↔ REF_ISSUE → RFC_WAIT → IDLE.
- The refresh timer starts at zero on the cycle `init_done` rises and wraps every tREFI cycles.
- Each wrap increments `pending`. A REF issue decrements `pending`. A wrap and an issue in the same cycle leave `pending` unchanged.
- A wrap while pending == MAX_PEND leaves `pending` at MAX_PEND and sets `ref_overflow`.
- `ref_req` is high only in IDLE while pending > 0.
- Grant handling:
  - `ref_gnt` is ignored when `ref_req` is low.
  - `ref_req`=1 and `ref_gnt`=1 sampled on an edge in IDLE → REF on the next cycle, and `ref_req` drops the same cycle REF is driven.
  - If `ref_gnt` drops before it is sampled together with `ref_req`, nothing is issued and `ref_req` stays high.
- The refresh timer keeps running during REF_ISSUE and RFC_WAIT.
- Reset asserted in any state forces reset values immediately (async). On release the full init sequence restarts from CKE_WAIT.
- The timer and delay counters are 16 bits. Parameters must be ≥ 1 and fit in 16 bits.

## Timing
- Let cycle R be the first posedge with reset_n=1.
- CKE rises at R+tCKE_DLY (call this C) and stays high thereafter.
- MRS3 at C+tXPR. MRS6, MRS5, MRS4, MRS2, MRS1, MRS0 each follow exactly tMRD cycles after the previous MRS.
- ZQCL at MRS0+tMOD.
- `init_done` rises at ZQCL+tZQ (call this D).
- First `ref_req` rises at D+tREFI.
- Refresh cycle, with the grant sampled at edge G:
  - REF at G+1.
  - `ref_busy` high from G+1 through G+tRFC.
  - State returns to IDLE at G+tRFC+1; `ref_req` may reassert that cycle if pending > 0.
- Minimum REF-to-REF spacing is tRFC+1 cycles.

## Test plan
- Reset release with default parameters, mr_cfg MRi = 14'h100+i → CKE at R+16. MRS3 at R+36 with bg=0, ba=3, addr=0x103. MRS6 at R+44 with bg=1, ba=2. MRS0 at R+84. ZQCL at R+108 with addr[10]=1. init_done at R+620.
- `ref_gnt` held high → REF at D+781. ref_busy high for 36 cycles. Next REF at D+1561. pending stays 0.
- `ref_gnt` held low for 5·tREFI, then high → pending=5. Five REFs follow, spaced 37 cycles apart. ref_overflow stays 0.
- `ref_gnt` held low for 9·tREFI → pending saturates at 8 and ref_overflow=1. After reset, ref_overflow=0.
- Timer wrap lands on the REF issue cycle → pending unchanged, and a second REF is issued 37 cycles later.
- reset_n pulsed low during MRD_WAIT after MRS5 → all outputs return to reset values immediately. After release the sequence restarts with CKE at R'+16 and MRS3 at R'+36.

Source files
------------

// File: rtl/ddr_init_refresh_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_init_refresh_ctrl_if
// Description : DDR4 command bus plus refresh req/gnt handshake between the
//               init/refresh controller (master) and the command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_init_refresh_ctrl_if;
  logic        CKE;
  logic        cs_n;
  logic        act_n;
  logic        RAS_n_A16;
  logic        CAS_n_A15;
  logic        WE_n_A14;
  logic [1:0]  bg_addr;
  logic [1:0]  ba_addr;
  logic [13:0] addr;
  logic        ref_req;
  logic        ref_gnt;
  logic        ref_busy;

  modport master (
    output CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    output bg_addr, ba_addr, addr, ref_req, ref_busy,
    input  ref_gnt
  );

  modport slave (
    input  CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    input  bg_addr, ba_addr, addr, ref_req, ref_busy,
    output ref_gnt
  );
endinterface
`default_nettype wire

// File: rtl/ddr_init_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr_init_refresh_ctrl
// Description : DDR4 power-up sequencer (CKE, MRS3..MRS0, ZQCL) followed by
//               a tREFI refresh scheduler with a saturating pending counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_init_refresh_ctrl #(
  parameter int tCKE_DLY = 16,
  parameter int tXPR     = 20,
  parameter int tMRD     = 8,
  parameter int tMOD     = 24,
  parameter int tZQ      = 512,
  parameter int tREFI    = 780,
  parameter int tRFC     = 36,
  parameter int MAX_PEND = 8
) (
  input  logic                      CK_t,
  input  logic                      reset_n,
  input  logic [97:0]               mr_cfg,
  ddr_init_refresh_ctrl_if.master   bus,
  output logic                      init_done,
  output logic                      ref_overflow
);

  localparam int PW = $clog2(MAX_PEND + 1);

  // Wait-state counters count from 0 after the launching edge, so a delay
  // of N cycles completes when the counter reads N-1. CKE_WAIT starts
  // counting on the first released edge, hence its limit is N itself.
  localparam logic [15:0]   CKE_LIM  = 16'(tCKE_DLY);
  localparam logic [15:0]   XPR_LIM  = 16'(tXPR - 1);
  localparam logic [15:0]   MRD_LIM  = 16'(tMRD - 1);
  localparam logic [15:0]   MOD_LIM  = 16'(tMOD - 1);
  localparam logic [15:0]   ZQ_LIM   = 16'(tZQ - 1);
  localparam logic [15:0]   REFI_LIM = 16'(tREFI - 1);
  localparam logic [15:0]   RFC_LIM  = 16'(tRFC - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  typedef enum logic [3:0] {
    CKE_WAIT, XPR_WAIT, MRS_ISSUE, MRD_WAIT, MOD_WAIT,
    ZQ_ISSUE, ZQ_WAIT, IDLE, REF_ISSUE, RFC_WAIT
  } state_t;

  typedef struct packed {
    logic        cs_n;
    logic        act_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] addr;
  } cmd_t;

  localparam cmd_t CMD_DES  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 14'h0000};
  localparam cmd_t CMD_ZQCL = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 14'h0400};
  localparam cmd_t CMD_REF  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 14'h0000};

  // Mode registers are programmed in the order 3,6,5,4,2,1,0.
  function automatic logic [2:0] mrs_idx(input logic [2:0] pos);
    case (pos)
      3'd0:    mrs_idx = 3'd3;
      3'd1:    mrs_idx = 3'd6;
      3'd2:    mrs_idx = 3'd5;
      3'd3:    mrs_idx = 3'd4;
      3'd4:    mrs_idx = 3'd2;
      3'd5:    mrs_idx = 3'd1;
      default: mrs_idx = 3'd0;
    endcase
  endfunction

  state_t        state;
  logic [15:0]   cnt;
  logic [15:0]   timer;
  logic [2:0]    seq;
  logic [PW-1:0] pending;
  logic [PW-1:0] pending_nxt;
  logic          cke_q;
  logic          ref_req_q;
  logic          ref_busy_q;
  logic          wrap;
  logic          issue;
  logic [2:0]    mrs_i;
  logic [13:0]   mrs_val;
  cmd_t          mrs_cmd;
  cmd_t          cmd_q;

  assign mrs_i   = mrs_idx(seq);
  assign mrs_val = mr_cfg[int'(mrs_i) * 14 +: 14];
  assign mrs_cmd = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {1'b0, mrs_i[2]}, mrs_i[1:0], mrs_val};

  // Refresh bookkeeping: timer wrap adds a pending refresh, a granted REF removes one.
  always_comb begin
    wrap        = init_done && (timer == REFI_LIM);
    issue       = (state == IDLE) && ref_req_q && bus.ref_gnt;
    pending_nxt = pending;
    if (wrap && !issue) begin
      if (pending != PEND_MAX) pending_nxt = pending + PW'(1);
    end else if (issue && !wrap) begin
      pending_nxt = pending - PW'(1);
    end
  end

  // Free-running tREFI timer, started from zero on the init_done edge.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      timer <= 16'd0;
    end else if (init_done) begin
      timer <= wrap ? 16'd0 : timer + 16'd1;
    end
  end

  // Pending-refresh counter and sticky overflow flag.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (wrap && (pending == PEND_MAX)) ref_overflow <= 1'b1;
    end
  end

  // Init sequencer and refresh issue FSM; the bus defaults to DES every cycle.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CKE_WAIT;
      cnt        <= 16'd0;
      seq        <= 3'd0;
      cke_q      <= 1'b0;
      cmd_q      <= CMD_DES;
      init_done  <= 1'b0;
      ref_req_q  <= 1'b0;
      ref_busy_q <= 1'b0;
    end else begin
      cmd_q <= CMD_DES;
      cnt   <= cnt + 16'd1;
      case (state)
        CKE_WAIT: begin
          if (cnt == CKE_LIM) begin
            cke_q <= 1'b1;
            cnt   <= 16'd0;
            state <= XPR_WAIT;
          end
        end
        XPR_WAIT: begin
          if (cnt == XPR_LIM) begin
            cmd_q <= mrs_cmd;
            seq   <= seq + 3'd1;
            cnt   <= 16'd0;
            state <= MRS_ISSUE;
          end
        end
        MRS_ISSUE, MRD_WAIT: begin
          if (seq == 3'd7) begin
            // All seven MRS sent; the gap to ZQCL is tMOD.
            if (cnt == MOD_LIM) begin
              cmd_q <= CMD_ZQCL;
              cnt   <= 16'd0;
              state <= ZQ_ISSUE;
            end else begin
              state <= MOD_WAIT;
            end
          end else if (cnt == MRD_LIM) begin
            cmd_q <= mrs_cmd;
            seq   <= seq + 3'd1;
            cnt   <= 16'd0;
            state <= MRS_ISSUE;
          end else begin
            state <= MRD_WAIT;
          end
        end
        MOD_WAIT: begin
          if (cnt == MOD_LIM) begin
            cmd_q <= CMD_ZQCL;
            cnt   <= 16'd0;
            state <= ZQ_ISSUE;
          end
        end
        ZQ_ISSUE, ZQ_WAIT: begin
          if (cnt == ZQ_LIM) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= ZQ_WAIT;
          end
        end
        IDLE: begin
          cnt <= 16'd0;
          if (issue) begin
            cmd_q      <= CMD_REF;
            ref_req_q  <= 1'b0;
            ref_busy_q <= 1'b1;
            state      <= REF_ISSUE;
          end else begin
            ref_req_q <= (pending_nxt != '0);
          end
        end
        REF_ISSUE, RFC_WAIT: begin
          if (cnt == RFC_LIM) begin
            ref_busy_q <= 1'b0;
            ref_req_q  <= (pending_nxt != '0);
            state      <= IDLE;
          end else begin
            state <= RFC_WAIT;
          end
        end
        default: state <= CKE_WAIT;
      endcase
    end
  end

  assign bus.CKE       = cke_q;
  assign bus.cs_n      = cmd_q.cs_n;
  assign bus.act_n     = cmd_q.act_n;
  assign bus.RAS_n_A16 = cmd_q.ras_n;
  assign bus.CAS_n_A15 = cmd_q.cas_n;
  assign bus.WE_n_A14  = cmd_q.we_n;
  assign bus.bg_addr   = cmd_q.bg;
  assign bus.ba_addr   = cmd_q.ba;
  assign bus.addr      = cmd_q.addr;
  assign bus.ref_req   = ref_req_q;
  assign bus.ref_busy  = ref_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_init_refresh_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddr_init_refresh_ctrl
// Description : Directed, table-driven bench for ddr_init_refresh_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_init_refresh_ctrl;

  typedef struct packed {
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic        ras;
    logic        cas;
    logic        we;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic        init;
    logic        req;
    logic        busy;
  } obs_t;

  typedef struct {
    int    t;
    obs_t  exp;
    string name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [97:0] mr_cfg;
  logic        init_done;
  logic        ref_overflow;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          R;
  int          D;
  vec_t        init_q[$];
  vec_t        ref_q[$];

  ddr_init_refresh_ctrl_if bus_if();

  ddr_init_refresh_ctrl dut (
    .CK_t         (clk),
    .reset_n      (reset_n),
    .mr_cfg       (mr_cfg),
    .bus          (bus_if.master),
    .init_done    (init_done),
    .ref_overflow (ref_overflow)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Posedge counter: after edge X, cyc == X.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic cke, cs, act, ras, cas, we,
                              input logic [1:0] bg, ba, input logic [13:0] a,
                              input logic init, req, busy);
    return {cke, cs, act, ras, cas, we, bg, ba, a, init, req, busy};
  endfunction

  function automatic obs_t des(input logic cke, init, req, busy);
    return mk(cke, 1, 1, 1, 1, 1, 2'd0, 2'd0, 14'h0, init, req, busy);
  endfunction

  function automatic obs_t sample();
    return {bus_if.CKE, bus_if.cs_n, bus_if.act_n, bus_if.RAS_n_A16, bus_if.CAS_n_A15,
            bus_if.WE_n_A14, bus_if.bg_addr, bus_if.ba_addr, bus_if.addr,
            init_done, bus_if.ref_req, bus_if.ref_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the negedge that follows posedge number x.
  task automatic goto(input int x);
    if (cyc > x) begin
      n_checks++;
      n_fail++;
      $display("FAIL goto: cycle %0d already past target %0d", cyc, x);
    end
    while (cyc < x) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    R = cyc + 1;
  endtask

  task automatic run_tab(input int base, input bit use_ref);
    int n;
    vec_t v;
    n = use_ref ? ref_q.size() : init_q.size();
    for (int i = 0; i < n; i++) begin
      v = use_ref ? ref_q[i] : init_q[i];
      goto(base + v.t);
      check($sformatf("%s@+%0d", v.name, v.t), 32'(sample()), 32'(v.exp));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, 32'(sample()), 32'(des(0, 0, 0, 0)));
    check({tag, "_ovf"}, 32'(ref_overflow), 32'd0);
    check({tag, "_pend"}, 32'(dut.pending), 32'd0);
  endtask

  initial begin
    // Init sequence expectations relative to R (MRi = 0x100+i).
    init_q.push_back('{0,   des(0, 0, 0, 0), "rst_state"});
    init_q.push_back('{15,  des(0, 0, 0, 0), "cke_low"});
    init_q.push_back('{16,  des(1, 0, 0, 0), "cke_rise"});
    init_q.push_back('{35,  des(1, 0, 0, 0), "pre_mrs3"});
    init_q.push_back('{36,  mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd3, 14'h103, 0, 0, 0), "mrs3"});
    init_q.push_back('{37,  des(1, 0, 0, 0), "post_mrs3"});
    init_q.push_back('{44,  mk(1, 0, 1, 0, 0, 0, 2'd1, 2'd2, 14'h106, 0, 0, 0), "mrs6"});
    init_q.push_back('{45,  des(1, 0, 0, 0), "post_mrs6"});
    init_q.push_back('{52,  mk(1, 0, 1, 0, 0, 0, 2'd1, 2'd1, 14'h105, 0, 0, 0), "mrs5"});
    init_q.push_back('{60,  mk(1, 0, 1, 0, 0, 0, 2'd1, 2'd0, 14'h104, 0, 0, 0), "mrs4"});
    init_q.push_back('{68,  mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd2, 14'h102, 0, 0, 0), "mrs2"});
    init_q.push_back('{76,  mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd1, 14'h101, 0, 0, 0), "mrs1"});
    init_q.push_back('{84,  mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 14'h100, 0, 0, 0), "mrs0"});
    init_q.push_back('{85,  des(1, 0, 0, 0), "post_mrs0"});
    init_q.push_back('{107, des(1, 0, 0, 0), "pre_zqcl"});
    init_q.push_back('{108, mk(1, 0, 1, 1, 1, 0, 2'd0, 2'd0, 14'h400, 0, 0, 0), "zqcl"});
    init_q.push_back('{109, des(1, 0, 0, 0), "post_zqcl"});
    init_q.push_back('{619, des(1, 0, 0, 0), "pre_init_done"});
    init_q.push_back('{620, des(1, 1, 0, 0), "init_done"});

    // Refresh with grant held high, relative to D.
    ref_q.push_back('{779,  des(1, 1, 0, 0), "pre_req"});
    ref_q.push_back('{780,  des(1, 1, 1, 0), "req1"});
    ref_q.push_back('{781,  mk(1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 14'h0, 1, 0, 1), "ref1"});
    ref_q.push_back('{782,  des(1, 1, 0, 1), "busy_start"});
    ref_q.push_back('{816,  des(1, 1, 0, 1), "busy_last"});
    ref_q.push_back('{817,  des(1, 1, 0, 0), "busy_end"});
    ref_q.push_back('{1560, des(1, 1, 1, 0), "req2"});
    ref_q.push_back('{1561, mk(1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 14'h0, 1, 0, 1), "ref2"});

    for (int i = 0; i < 7; i++) mr_cfg[14*i +: 14] = 14'(14'h100 + i);
    bus_if.ref_gnt = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();

    // Power-up sequence and first refreshes with grant held high
    run_tab(R, 1'b0);
    D = R + 620;
    run_tab(D, 1'b1);
    check("pend_after_ref2", 32'(dut.pending), 32'd0);

    // Five refreshes postponed, then drained back-to-back
    goto(D + 1600);
    bus_if.ref_gnt = 1'b0;
    goto(D + 5461);
    check("pend5", 32'(dut.pending), 32'd5);
    check("pend5_req", 32'(bus_if.ref_req), 32'd1);
    bus_if.ref_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      goto(D + 5462 + 37 * k - 1);
      check($sformatf("drain_pre%0d", k), 32'(bus_if.cs_n), 32'd1);
      goto(D + 5462 + 37 * k);
      check($sformatf("drain_ref%0d", k), 32'(sample()),
            32'(mk(1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 14'h0, 1, 0, 1)));
    end
    goto(D + 5647);
    check("drained_idle", 32'(sample()), 32'(des(1, 1, 0, 0)));
    check("drained_pend", 32'(dut.pending), 32'd0);
    check("drained_ovf", 32'(ref_overflow), 32'd0);

    // Timer wrap coincides with the REF issue cycle
    bus_if.ref_gnt = 1'b0;
    goto(D + 6241);
    check("wrap_req", 32'(bus_if.ref_req), 32'd1);
    goto(D + 7019);
    check("wrap_pre_pend", 32'(dut.pending), 32'd1);
    bus_if.ref_gnt = 1'b1;
    goto(D + 7020);
    check("wrap_ref", 32'(sample()), 32'(mk(1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 14'h0, 1, 0, 1)));
    check("wrap_pend", 32'(dut.pending), 32'd1);
    goto(D + 7056);
    check("wrap_req_again", 32'(sample()), 32'(des(1, 1, 1, 0)));
    goto(D + 7057);
    check("wrap_ref2", 32'(sample()), 32'(mk(1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 14'h0, 1, 0, 1)));
    check("wrap_pend2", 32'(dut.pending), 32'd0);
    bus_if.ref_gnt = 1'b0;

    // Saturation and overflow
    goto(D + 13260);
    check("sat_pend8", 32'(dut.pending), 32'd8);
    check("sat_no_ovf", 32'(ref_overflow), 32'd0);
    goto(D + 14040);
    check("ovf_pend", 32'(dut.pending), 32'd8);
    check("ovf_set", 32'(ref_overflow), 32'd1);
    check("ovf_req", 32'(bus_if.ref_req), 32'd1);

    // Asynchronous reset clears everything mid-cycle
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_after_ovf");
    release_reset();

    // Reset pulse during MRD_WAIT after MRS5
    goto(R + 16);
    check("r2_cke", 32'(bus_if.CKE), 32'd1);
    goto(R + 36);
    check("r2_mrs3", 32'(sample()), 32'(mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd3, 14'h103, 0, 0, 0)));
    goto(R + 52);
    check("r2_mrs5", 32'(sample()), 32'(mk(1, 0, 1, 0, 0, 0, 2'd1, 2'd1, 14'h105, 0, 0, 0)));
    goto(R + 55);
    check("r2_mrd_wait", 32'(sample()), 32'(des(1, 0, 0, 0)));
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_in_mrd");
    release_reset();
    run_tab(R, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
